// File: rtl/box_motion_ctrl.sv
// Per-frame bouncing-box motion engine: steps X, then Y, then publishes atomically in blanking.
// Optional macro BOX_CORNER_FLASH_EN: a corner hit forces white and pulses the corner output.
module box_motion_ctrl #(
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned BOX_WIDTH     = 100,
  parameter int unsigned BOX_HEIGHT    = 100,
  parameter int unsigned SPEED_X       = 2,
  parameter int unsigned SPEED_Y       = 1,
  parameter int unsigned INIT_X        = 50,
  parameter int unsigned INIT_Y        = 50
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             vsync,
  input  logic                             run,
  output logic [$clog2(SCREEN_WIDTH)-1:0]  box_x,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] box_y,
  output logic [2:0]                       color,
  output logic                             bounce,
  output logic                             busy
`ifdef BOX_CORNER_FLASH_EN
  ,
  output logic                             corner
`endif
);

  localparam int unsigned XW  = $clog2(SCREEN_WIDTH);
  localparam int unsigned YW  = $clog2(SCREEN_HEIGHT);
  localparam int unsigned XW1 = XW + 1;
  localparam int unsigned YW1 = YW + 1;

  localparam logic [XW:0] MaxX = XW1'(SCREEN_WIDTH - BOX_WIDTH);
  localparam logic [YW:0] MaxY = YW1'(SCREEN_HEIGHT - BOX_HEIGHT);
  localparam logic [XW:0] SpdX = XW1'(SPEED_X);
  localparam logic [YW:0] SpdY = YW1'(SPEED_Y);

  typedef enum logic [1:0] {StIdle, StStepX, StStepY, StCommit} state_e;

  state_e          state_q;
  logic            vsync_prev_q;
  logic            dir_x_q, dir_y_q;
  logic [XW-1:0]   nx_q;
  logic [YW-1:0]   ny_q;
  logic            ndx_q, ndy_q, hit_x_q, hit_y_q;

  logic            start;
  logic [XW:0]     sum_x;
  logic [YW:0]     sum_y;
  logic [XW-1:0]   nx_c;
  logic [YW-1:0]   ny_c;
  logic            ndx_c, ndy_c, hit_x_c, hit_y_c;
  logic [2:0]      color_c;

  assign start = (state_q == StIdle) && run && vsync_prev_q && !vsync;

  // One extra bit on the sums so the upper clamp compare can never wrap.
  always_comb begin
    sum_x   = {1'b0, box_x} + SpdX;
    nx_c    = sum_x[XW-1:0];
    ndx_c   = dir_x_q;
    hit_x_c = 1'b0;
    if (!dir_x_q) begin
      if (sum_x >= MaxX) begin
        nx_c    = MaxX[XW-1:0];
        ndx_c   = 1'b1;
        hit_x_c = 1'b1;
      end
    end else if ({1'b0, box_x} <= SpdX) begin
      nx_c    = '0;
      ndx_c   = 1'b0;
      hit_x_c = 1'b1;
    end else begin
      nx_c = box_x - SpdX[XW-1:0];
    end
  end

  always_comb begin
    sum_y   = {1'b0, box_y} + SpdY;
    ny_c    = sum_y[YW-1:0];
    ndy_c   = dir_y_q;
    hit_y_c = 1'b0;
    if (!dir_y_q) begin
      if (sum_y >= MaxY) begin
        ny_c    = MaxY[YW-1:0];
        ndy_c   = 1'b1;
        hit_y_c = 1'b1;
      end
    end else if ({1'b0, box_y} <= SpdY) begin
      ny_c    = '0;
      ndy_c   = 1'b0;
      hit_y_c = 1'b1;
    end else begin
      ny_c = box_y - SpdY[YW-1:0];
    end
  end

  always_comb begin
    color_c = color;
`ifdef BOX_CORNER_FLASH_EN
    if (hit_x_q && hit_y_q) begin
      color_c = 3'b111;
    end else if (hit_x_q || hit_y_q) begin
      color_c = (color == 3'd7) ? 3'd1 : color + 3'd1;
    end
`else
    if (hit_x_q || hit_y_q) begin
      color_c = (color == 3'd7) ? 3'd1 : color + 3'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      vsync_prev_q <= 1'b1;
      dir_x_q      <= 1'b0;
      dir_y_q      <= 1'b0;
      nx_q         <= '0;
      ny_q         <= '0;
      ndx_q        <= 1'b0;
      ndy_q        <= 1'b0;
      hit_x_q      <= 1'b0;
      hit_y_q      <= 1'b0;
      box_x        <= XW'(INIT_X);
      box_y        <= YW'(INIT_Y);
      color        <= 3'b111;
      bounce       <= 1'b0;
      busy         <= 1'b0;
`ifdef BOX_CORNER_FLASH_EN
      corner       <= 1'b0;
`endif
    end else begin
      vsync_prev_q <= vsync;
      bounce       <= 1'b0;
`ifdef BOX_CORNER_FLASH_EN
      corner       <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StStepX;
            busy    <= 1'b1;
          end
        end
        StStepX: begin
          nx_q    <= nx_c;
          ndx_q   <= ndx_c;
          hit_x_q <= hit_x_c;
          state_q <= StStepY;
        end
        StStepY: begin
          ny_q    <= ny_c;
          ndy_q   <= ndy_c;
          hit_y_q <= hit_y_c;
          state_q <= StCommit;
        end
        StCommit: begin
          box_x   <= nx_q;
          box_y   <= ny_q;
          dir_x_q <= ndx_q;
          dir_y_q <= ndy_q;
          color   <= color_c;
          bounce  <= hit_x_q | hit_y_q;
`ifdef BOX_CORNER_FLASH_EN
          corner  <= hit_x_q & hit_y_q;
`endif
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Randomized bench for box_motion_ctrl: two instances (default and a small 140x120 screen)
// checked every cycle of each frame against a position/direction/colour reference model.
module tb_box_motion_ctrl;

  logic clk = 1'b0;
  logic rst, vsync, run;
  always #5 clk = ~clk;

  logic [9:0] a_x;
  logic [8:0] a_y;
  logic [2:0] a_col;
  logic       a_bnc, a_busy;
  logic [7:0] b_x;
  logic [6:0] b_y;
  logic [2:0] b_col;
  logic       b_bnc, b_busy;
`ifdef BOX_CORNER_FLASH_EN
  logic       a_cor, b_cor;
`endif

  box_motion_ctrl dut_a (
    .clk(clk), .rst(rst), .vsync(vsync), .run(run),
    .box_x(a_x), .box_y(a_y), .color(a_col), .bounce(a_bnc), .busy(a_busy)
`ifdef BOX_CORNER_FLASH_EN
    , .corner(a_cor)
`endif
  );

  box_motion_ctrl #(
    .SCREEN_WIDTH(140), .SCREEN_HEIGHT(120), .BOX_WIDTH(100), .BOX_HEIGHT(100),
    .SPEED_X(2), .SPEED_Y(1), .INIT_X(0), .INIT_Y(0)
  ) dut_b (
    .clk(clk), .rst(rst), .vsync(vsync), .run(run),
    .box_x(b_x), .box_y(b_y), .color(b_col), .bounce(b_bnc), .busy(b_busy)
`ifdef BOX_CORNER_FLASH_EN
    , .corner(b_cor)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, index 0 = default instance, 1 = small instance.
  int mx[2], my[2], mc[2];
  bit mdx[2], mdy[2], mhit[2], mcor[2];
  bit last_a_bnc, last_b_bnc;

  function automatic int max_x(input int i); return (i == 0) ? 540 : 40; endfunction
  function automatic int max_y(input int i); return (i == 0) ? 380 : 20; endfunction
  function automatic int init_p(input int i); return (i == 0) ? 50 : 0; endfunction

  // dir 0 = moving toward larger coordinates.
  function automatic void move(input int pos, input bit dir, input int spd, input int lim,
                               output int npos, output bit ndir, output bit hit);
    npos = pos; ndir = dir; hit = 1'b0;
    if (!dir) begin
      if (pos + spd >= lim) begin npos = lim; ndir = 1'b1; hit = 1'b1; end
      else npos = pos + spd;
    end else begin
      if (pos <= spd) begin npos = 0; ndir = 1'b0; hit = 1'b1; end
      else npos = pos - spd;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = init_p(i); my[i] = init_p(i); mc[i] = 7;
      mdx[i] = 1'b0; mdy[i] = 1'b0; mhit[i] = 1'b0; mcor[i] = 1'b0;
    end
  endtask

  task automatic model_frame();
    int nx, ny;
    bit dx, dy, hx, hy;
    for (int i = 0; i < 2; i++) begin
      move(mx[i], mdx[i], 2, max_x(i), nx, dx, hx);
      move(my[i], mdy[i], 1, max_y(i), ny, dy, hy);
      mx[i] = nx; my[i] = ny; mdx[i] = dx; mdy[i] = dy;
      mhit[i] = hx | hy;
      mcor[i] = hx & hy;
`ifdef BOX_CORNER_FLASH_EN
      if (mcor[i]) mc[i] = 7;
      else if (mhit[i]) mc[i] = (mc[i] == 7) ? 1 : mc[i] + 1;
`else
      if (mhit[i]) mc[i] = (mc[i] == 7) ? 1 : mc[i] + 1;
`endif
    end
  endtask

  task automatic check_all(input string tag, input bit exp_busy, input bit pulse);
    check({tag, "/a_x"}, int'(a_x), mx[0]);
    check({tag, "/a_y"}, int'(a_y), my[0]);
    check({tag, "/a_col"}, int'(a_col), mc[0]);
    check({tag, "/a_busy"}, int'(a_busy), int'(exp_busy));
    check({tag, "/a_bnc"}, int'(a_bnc), int'(pulse & mhit[0]));
    check({tag, "/b_x"}, int'(b_x), mx[1]);
    check({tag, "/b_y"}, int'(b_y), my[1]);
    check({tag, "/b_col"}, int'(b_col), mc[1]);
    check({tag, "/b_busy"}, int'(b_busy), int'(exp_busy));
    check({tag, "/b_bnc"}, int'(b_bnc), int'(pulse & mhit[1]));
`ifdef BOX_CORNER_FLASH_EN
    check({tag, "/a_cor"}, int'(a_cor), int'(pulse & mcor[0]));
    check({tag, "/b_cor"}, int'(b_cor), int'(pulse & mcor[1]));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One published frame; optionally a second falling edge mid-update and run dropped after start.
  task automatic do_frame(input bit inject, input bit drop_run);
    run = 1'b1;
    vsync = 1'b0;
    tick();
    check_all("e0", 1'b1, 1'b0);
    if (inject) vsync = 1'b1;
    if (drop_run) run = 1'b0;
    tick();
    check_all("e1", 1'b1, 1'b0);
    if (inject) vsync = 1'b0;
    tick();
    check_all("e2", 1'b1, 1'b0);
    tick();
    model_frame();
    last_a_bnc = a_bnc;
    last_b_bnc = b_bnc;
    check_all("e3", 1'b0, 1'b1);
    vsync = 1'b1;
    tick();
    check_all("post", 1'b0, 1'b0);
  endtask

  task automatic frozen_edges();
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vsync = 1'b0;
      tick();
      check_all("frz_lo", 1'b0, 1'b0);
      tick();
      check_all("frz_lo2", 1'b0, 1'b0);
      vsync = 1'b1;
      tick();
      check_all("frz_hi", 1'b0, 1'b0);
    end
    run = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    vsync = 1'b1;
    run = 1'b0;
    model_reset();
    repeat (3) tick();
    check_all("reset", 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    for (int f = 1; f <= 560; f++) begin
      if (f > 1 && $urandom_range(0, 15) == 0) frozen_edges();
      do_frame((f > 1) && ($urandom_range(0, 3) == 0), (f > 1) && ($urandom_range(0, 3) == 0));
      if (f == 1) begin
        check("f1_x", int'(a_x), 52);
        check("f1_y", int'(a_y), 51);
        check("f1_col", int'(a_col), 7);
        check("f1_bnc", int'(last_a_bnc), 0);
      end
      if (f == 20) begin
        check("f20_bx", int'(b_x), 40);
        check("f20_by", int'(b_y), 20);
        check("f20_bbnc", int'(last_b_bnc), 1);
`ifdef BOX_CORNER_FLASH_EN
        check("f20_bcol", int'(b_col), 7);
`else
        check("f20_bcol", int'(b_col), 1);
`endif
      end
      if (f == 244) check("f244_x", int'(a_x), 538);
      if (f == 245) begin
        check("f245_x", int'(a_x), 540);
        check("f245_bnc", int'(last_a_bnc), 1);
        check("f245_col", int'(a_col), 1);
      end
      if (f == 246) check("f246_x", int'(a_x), 538);
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        run = 1'($urandom_range(0, 1));
        tick();
        check_all("idle", 1'b0, 1'b0);
      end
    end

    // Reset while the update sits in STEP_Y must abandon it without a publish.
    run = 1'b1;
    vsync = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    model_reset();
    check_all("rst_mid", 1'b0, 1'b0);
    rst = 1'b0;
    vsync = 1'b1;
    tick();
    check_all("rst_after", 1'b0, 1'b0);
    do_frame(1'b0, 1'b0);
    check("rr_x", int'(a_x), 52);
    check("rr_y", int'(a_y), 51);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
